seq_mult: RTL

- Parametrised iterative multiplier; the sequential successor to the combinational 8-bit multiplier.
- Processes BITS_PER_CYCLE multiplier bits per clock using shift-add, with an unsigned or signed mode selected per operation.
- Valid/ready handshake on input and output. Sits between operand producers and the result consumer in the arithmetic datapath.

---
 rtl/seq_mult.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, BITS_PER_CYCLE multiplier bits per step, unsigned or signed per operation.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier magnitude is zero.
module seq_mult #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_result;
    logic [WIDTH-1:0] r_mult;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;

    logic [PW-1:0]    w_partial;
    logic [PW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_mult_next;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;

    // Negating the most-negative value wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_a_mag = (signed_mode && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign w_b_mag = (signed_mode && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // The multiplicand register is pre-shifted, so each digit's product lands at its own weight.
    assign w_partial   = r_mcand * PW'(r_mult[BITS_PER_CYCLE-1:0]);
    assign w_acc_next  = r_acc + w_partial;
    assign w_mult_next = r_mult >> BITS_PER_CYCLE;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == CNT_W'(N - 1)) || (w_mult_next == '0);
`else
    assign w_last = (r_cnt == CNT_W'(N - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_mult   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= PW'(w_a_mag);
                        r_mult  <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= signed_mode & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand << BITS_PER_CYCLE;
                    r_mult  <= w_mult_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_result <= r_neg ? -w_acc_next : w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule
